// File: rtl/cache_arbiter.sv
// Shares one physical memory port between the I-cache and D-cache line-miss ports.
// One line transaction in flight; D wins when uncontended, contention alternates.
module cache_arbiter #(
    parameter int unsigned LINE_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;

    logic [1:0]            r_state;
    logic                  r_last_d;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [LINE_WIDTH-1:0] r_mem_wdata;

    logic w_i_pend;
    logic w_d_pend;
    logic w_grant_d;
    logic w_grant_i;

    assign w_i_pend = i_pmem_read;
    assign w_d_pend = d_pmem_read | d_pmem_write;

    // Under contention the side that did not win last time goes next.
    assign w_grant_d = (r_state == IDLE) & w_d_pend & (~w_i_pend | ~r_last_d);
    assign w_grant_i = (r_state == IDLE) & w_i_pend & ~w_grant_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_last_d      <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state       <= SERVE_D;
                        r_last_d      <= 1'b1;
                        r_mem_read    <= d_pmem_read;
                        r_mem_write   <= d_pmem_write;
                        r_mem_address <= d_pmem_address;
                        r_mem_wdata   <= d_pmem_wdata;
                    end else if (w_grant_i) begin
                        r_state       <= SERVE_I;
                        r_last_d      <= 1'b0;
                        r_mem_read    <= 1'b1;
                        r_mem_write   <= 1'b0;
                        r_mem_address <= i_pmem_address;
                    end
                end
                SERVE_I, SERVE_D: begin
                    // Requesters dropping mid-flight are ignored; only mem_resp ends it.
                    if (mem_resp) begin
                        r_state     <= IDLE;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

    assign mem_read     = r_mem_read;
    assign mem_write    = r_mem_write;
    assign mem_address  = r_mem_address;
    assign mem_wdata    = r_mem_wdata;

    assign i_pmem_resp  = (r_state == SERVE_I) & mem_resp;
    assign d_pmem_resp  = (r_state == SERVE_D) & mem_resp;
    assign i_pmem_rdata = mem_rdata;
    assign d_pmem_rdata = mem_rdata;

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates between the instruction-cache and data-cache line-miss ports for the single physical memory port. Sits between the two caches and the burst cacheline adaptor. Its per-side `resp` outputs are the `i_mem_resp`/`d_mem_resp` qualifiers the hazard detector uses to hold the pipeline. Exactly one line transaction is outstanding at a time. Grant is D-priority with alternation on contention.

## Interface
- `LINE_WIDTH`, 256, cacheline width in bits.
- `ADDR_WIDTH`, 32, line address width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_pmem_read`  in  1  I-cache line read request; held until `i_pmem_resp`.
- `i_pmem_address`  in  ADDR_WIDTH  I-cache line address.
- `i_pmem_rdata`  out  LINE_WIDTH  returned line (valid when `i_pmem_resp`).
- `i_pmem_resp`  out  1  I-side completion strobe.
- `d_pmem_read`, `d_pmem_write`  in  1  D-cache line read / writeback request; never both high.
- `d_pmem_address`  in  ADDR_WIDTH  D-cache line address.
- `d_pmem_wdata`  in  LINE_WIDTH  writeback line.
- `d_pmem_rdata`  out  LINE_WIDTH  returned line.
- `d_pmem_resp`  out  1  D-side completion strobe.
- `mem_read`, `mem_write`  out  1  request to cacheline adaptor.
- `mem_address`  out  ADDR_WIDTH  registered request address.
- `mem_wdata`  out  LINE_WIDTH  registered write line.
- `mem_rdata`  in  LINE_WIDTH  line from adaptor.
- `mem_resp`  in  1  adaptor completion, one-cycle pulse.

## Operation
- States: `IDLE`, `SERVE_I`, `SERVE_D`. One-bit `last_d` records the most recent grant was D.
- `IDLE`:
  - D pending only (`d_pmem_read|d_pmem_write`) -> `SERVE_D`.
  - I pending only -> `SERVE_I`.
  - Both pending: `SERVE_I` if `last_d`=1, else `SERVE_D`.
  - Neither pending: stay in `IDLE`.
- On the granting edge, latch the following:
  - `mem_address` from the winner.
  - `mem_wdata` (D only).
  - `mem_read`/`mem_write` from the winner's command; I side is always read.
  - `last_d` = (winner is D).
- `SERVE_x`: hold all `mem_*` outputs constant. On `mem_resp`=1, deassert `mem_read`/`mem_write` and return to `IDLE` at that edge.
- `i_pmem_resp` = (`state`==`SERVE_I`) & `mem_resp`. `d_pmem_resp` = (`state`==`SERVE_D`) & `mem_resp`. Both are combinational, never high together.
- `i_pmem_rdata` and `d_pmem_rdata` both = `mem_rdata`. Consumers must qualify with their own `resp`.
- Requester deasserting mid-transaction is ignored. The transaction completes and the `resp` strobe still fires.
- `mem_resp` in `IDLE` is ignored: no `resp` strobes, no state change.

## Timing
- Reset values: `state`=`IDLE`, `last_d`=0, `mem_read`=`mem_write`=0, `mem_address`=0, `mem_wdata`=0. `resp` outputs are 0 because `state`=`IDLE`.
- `rst` mid-transaction forces `IDLE` and drops `mem_read`/`mem_write` at the next edge. The in-flight response is discarded; the adaptor must be reset with the same `rst`.
- Request seen high at edge t (in `IDLE`) -> `mem_read`/`mem_write` high from cycle t+1.
- `mem_resp` in cycle k -> requester `resp` in cycle k. `mem_read`/`mem_write` low in k+1 (`IDLE`). The earliest next grant is visible in k+2, so there is one mandatory bubble cycle.
- Total latency request -> `resp` = 1 + adaptor latency. There is no combinational path from request inputs to `mem_*` outputs.

## Test plan
- Reset: hold `rst` 2 cycles with all requests high. Required: all `mem_*` = 0, both `resp` = 0 during reset, first grant after release is D (`last_d`=0).
- Single I read: `i_pmem_read`=1, addr 0x0000_1000; adaptor responds 4 cycles after `mem_read`. Required:
  - `mem_read`=1 from cycle 1 with addr 0x0000_1000.
  - `i_pmem_resp`=1 only on the `mem_resp` cycle, `i_pmem_rdata`=`mem_rdata`.
  - `d_pmem_resp` stays 0.
- D writeback: `d_pmem_write`=1, addr 0x0000_2000, wdata 0xA5 repeated. Required: `mem_write`=1 with those values, held stable until `mem_resp`. `d_pmem_resp` pulses 1 cycle.
- Contention alternation: I and D both requesting continuously, three transactions. Required grant order is D, I, D, each transaction separated by exactly one idle cycle.
- Requester drops early: D read withdrawn 1 cycle after grant. Required: `mem_read` stays high until `mem_resp`, `d_pmem_resp` still pulses, then the pending I request is granted.
- Reset mid-transaction: assert `rst` while in `SERVE_I`. Required: `mem_read`=0 the next cycle, no `i_pmem_resp`, and a stray `mem_resp` in `IDLE` is ignored.
